wb_commit_arbiter: RTL and testbench
====================================

Name: wb_commit_arbiter

Overview:
Writeback stage for the MIPS pipeline, with a parametrised auxiliary result channel for long-latency units such as a multi-cycle MD unit. It decodes the WB-stage instruction into a GRF write class (ALU, load or link) and extends sub-word load data. It arbitrates the single GRF write port between the pipeline and a DEPTH-entry aux FIFO, with anti-starvation and pending-write lookup for the hazard unit. The block sits between the MEM/WB register and the GRF.

Parameters:
DATA_W, 32, GRF data width
REG_AW, 5, GRF address width
AUX_DEPTH, 4, aux FIFO entries; power of two, >=2
STARVE_LIMIT, 8, consecutive cycles aux may be blocked while non-empty before a forced drain

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
wb_valid  in  1  WB-stage instruction present
wb_instr  in  32  WB-stage instruction word
wb_pc8  in  DATA_W  PC+8 (link value)
wb_alu  in  DATA_W  ALU/HI/LO/CP0 result
wb_dm  in  DATA_W  raw DM word
wb_addr_lo  in  2  low address bits of the load
wb_reg  in  REG_AW  destination register
aux_valid  in  1  aux result offered
aux_reg  in  REG_AW  aux destination
aux_data  in  DATA_W  aux result
aux_ready  out  1  FIFO can accept this cycle
wb_stall  out  1  WB slot taken by aux; pipeline must hold the WB instruction
query_reg  in  REG_AW  hazard-unit lookup register
pend_hit  out  1  query_reg has a pending aux write
fifo_count  out  clog2(AUX_DEPTH)+1  occupancy
grf_we  out  1  GRF write enable (registered)
grf_a3  out  REG_AW  GRF write address (registered)
grf_wd  out  DATA_W  GRF write data (registered)

Behaviour:
- Single clock domain: clk. Reset is synchronous and active-high.
- Reset, including mid-operation: grf_we=0, grf_a3=0, grf_wd=0, FIFO emptied (pointers 0, fifo_count=0), starve counter 0. Any FIFO contents are discarded.
- Decode, combinational:
  - write: ori/xori/andi/slti/sltiu/addi/addiu/lui, R-type ALU/shift ops, mfhi/mflo, mfc0, sll with nonzero word.
  - load: lw/lb/lbu/lh/lhu.
  - link: jal, jalr.
  - no write: branches, j, jr, stores, mthi/mtlo, mult/multu/div/divu, mtc0, nop, unknown opcodes.
- Load extension (little-endian):
  - lb/lbu: byte wb_addr_lo, sign- or zero-extended.
  - lh/lhu: half at wb_addr_lo[1], sign- or zero-extended.
  - lw: full word.
- P (pipeline request) = wb_valid & decoded write & wb_reg!=0.
- Register-0 writes are never issued. aux_reg==0 is accepted but not stored.
- aux_ready = (fifo_count < AUX_DEPTH). It does not depend on a same-cycle pop, so no push occurs when full.
- Push on aux_valid & aux_ready & aux_reg!=0.
- wb_stall = FIFO non-empty & starve_cnt==STARVE_LIMIT (combinational from state). While wb_stall=1, pipeline inputs are ignored that cycle.
- Pop head when FIFO non-empty & (!P | wb_stall).
- Commit (registered, 1-cycle latency): pop -> we=1, head reg/data. Otherwise P -> we=1, wb_reg, selected data. Otherwise we=0; grf_a3 and grf_wd hold their previous values.
- Starve counter:
  - cleared when FIFO empty or on a pop.
  - otherwise +1 per cycle while P blocks a non-empty FIFO.
  - saturates at STARVE_LIMIT.
- Simultaneous push and pop: both occur; count unchanged.
- Push into an empty FIFO is not committed the same cycle; earliest commit is the next cycle.
- Pointers wrap modulo AUX_DEPTH.
- pend_hit = query_reg!=0 & matches any valid FIFO entry (combinational). Readers must stall on it. WAW ordering between aux and pipeline is enforced by the hazard unit, not here.

Test Plan:
1. Link/no-write: jal, wb_reg=31, wb_pc8=0x3008 -> next cycle grf_we=1, grf_a3=31, grf_wd=0x3008. sw -> grf_we=0. addu to reg 0 -> grf_we=0.
2. Load extension with wb_dm=0x80FF1234:
   - lb, addr_lo=3 -> 0xFFFFFF80.
   - lbu, addr_lo=3 -> 0x00000080.
   - lh, addr_lo=2 -> 0xFFFF80FF.
   - lhu, addr_lo=2 -> 0x000080FF.
   - lw -> 0x80FF1234.
3. Aux with idle pipeline: push reg 5, 0xDEAD -> next cycle aux_ready=1, fifo_count=1. Following cycle grf_we=1, a3=5, wd=0xDEAD, and fifo_count=0.
4. Full and starvation: pipeline writes every cycle while 4 aux pushes occur -> fifo_count=4, aux_ready=0. Once starve_cnt reaches 8, wb_stall=1 for one cycle, head committed, fifo_count=3, counter cleared.
5. pend_hit: FIFO holds regs 7 and 9. query 9 -> 1. query 8 -> 0. query 0 -> 0. After both drain, query 9 -> 0.
6. Reset mid-operation with 3 FIFO entries and a pending commit -> next cycle fifo_count=0, grf_we=0, wb_stall=0, aux_ready=1.

Source files
------------

// File: rtl/wb_commit_arbiter.sv
// MIPS writeback stage: decodes the GRF write class, extends load data and
// shares the single GRF write port with a small aux-result FIFO.
module wb_commit_arbiter #(
  parameter int DATA_W       = 32,
  parameter int REG_AW       = 5,
  parameter int AUX_DEPTH    = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wb_valid,
  input  logic [31:0]                  wb_instr,
  input  logic [DATA_W-1:0]            wb_pc8,
  input  logic [DATA_W-1:0]            wb_alu,
  input  logic [DATA_W-1:0]            wb_dm,
  input  logic [1:0]                   wb_addr_lo,
  input  logic [REG_AW-1:0]            wb_reg,
  input  logic                         aux_valid,
  input  logic [REG_AW-1:0]            aux_reg,
  input  logic [DATA_W-1:0]            aux_data,
  output logic                         aux_ready,
  output logic                         wb_stall,
  input  logic [REG_AW-1:0]            query_reg,
  output logic                         pend_hit,
  output logic [$clog2(AUX_DEPTH):0]   fifo_count,
  output logic                         grf_we,
  output logic [REG_AW-1:0]            grf_a3,
  output logic [DATA_W-1:0]            grf_wd
);
  localparam int PW = $clog2(AUX_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [5:0]        op, fn;
  logic [4:0]        rs;
  logic              is_alu, is_load, is_link;
  logic [7:0]        ld_b;
  logic [15:0]       ld_h;
  logic [DATA_W-1:0] ld_ext, wb_data;
  logic              p_req, nonempty, push, pop;
  logic [PW-1:0]     off;

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [REG_AW-1:0] mem_reg_q [AUX_DEPTH];
  logic [REG_AW-1:0] mem_reg_d [AUX_DEPTH];
  logic [DATA_W-1:0] mem_data_q [AUX_DEPTH];
  logic [DATA_W-1:0] mem_data_d [AUX_DEPTH];
  logic              grf_we_q, grf_we_d;
  logic [REG_AW-1:0] grf_a3_q, grf_a3_d;
  logic [DATA_W-1:0] grf_wd_q, grf_wd_d;

  assign op = wb_instr[31:26];
  assign fn = wb_instr[5:0];
  assign rs = wb_instr[25:21];

  always_comb begin
    is_alu  = 1'b0;
    is_load = 1'b0;
    is_link = 1'b0;
    case (op)
      6'h00: begin
        case (fn)
          6'h00: is_alu = |wb_instr;
          6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
          6'h10, 6'h12,
          6'h20, 6'h21, 6'h22, 6'h23,
          6'h24, 6'h25, 6'h26, 6'h27,
          6'h2a, 6'h2b: is_alu = 1'b1;
          6'h09: is_link = 1'b1;
          default: ;
        endcase
      end
      6'h08, 6'h09, 6'h0a, 6'h0b,
      6'h0c, 6'h0d, 6'h0e, 6'h0f: is_alu = 1'b1;
      6'h10: is_alu = (rs == 5'h00);
      6'h03: is_link = 1'b1;
      6'h20, 6'h21, 6'h23,
      6'h24, 6'h25: is_load = 1'b1;
      default: ;
    endcase
  end

  // op[2] marks unsigned loads, op[1:0] the access size
  always_comb begin
    ld_b = wb_dm[{wb_addr_lo, 3'b000} +: 8];
    ld_h = wb_dm[{wb_addr_lo[1], 4'b0000} +: 16];
    case (op[1:0])
      2'b00: ld_ext = {{(DATA_W-8){ld_b[7] & ~op[2]}}, ld_b};
      2'b01: ld_ext = {{(DATA_W-16){ld_h[15] & ~op[2]}}, ld_h};
      default: ld_ext = wb_dm;
    endcase
    unique case (1'b1)
      is_link: wb_data = wb_pc8;
      is_load: wb_data = ld_ext;
      default: wb_data = wb_alu;
    endcase
  end

  assign p_req     = wb_valid & (is_alu | is_load | is_link) & (wb_reg != '0);
  assign nonempty  = (count_q != '0);
  assign aux_ready = (count_q < CW'(AUX_DEPTH));
  assign wb_stall  = nonempty & (starve_q == SW'(STARVE_LIMIT));
  assign push      = aux_valid & aux_ready & (aux_reg != '0);
  assign pop       = nonempty & (~p_req | wb_stall);

  always_comb begin
    pend_hit = 1'b0;
    off      = '0;
    for (int i = 0; i < AUX_DEPTH; i++) begin
      off = PW'(i) - rd_ptr_q;
      if (({1'b0, off} < count_q) && (mem_reg_q[i] == query_reg))
        pend_hit = 1'b1;
    end
    if (query_reg == '0)
      pend_hit = 1'b0;
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    mem_reg_d  = mem_reg_q;
    mem_data_d = mem_data_q;
    if (push) begin
      mem_reg_d[wr_ptr_q]  = aux_reg;
      mem_data_d[wr_ptr_q] = aux_data;
    end
    starve_d = starve_q;
    if (!nonempty || pop)
      starve_d = '0;
    else if (p_req && starve_q != SW'(STARVE_LIMIT))
      starve_d = starve_q + 1'b1;
  end

  always_comb begin
    grf_we_d = 1'b0;
    grf_a3_d = grf_a3_q;
    grf_wd_d = grf_wd_q;
    if (pop) begin
      grf_we_d = 1'b1;
      grf_a3_d = mem_reg_q[rd_ptr_q];
      grf_wd_d = mem_data_q[rd_ptr_q];
    end else if (p_req) begin
      grf_we_d = 1'b1;
      grf_a3_d = wb_reg;
      grf_wd_d = wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      grf_we_q <= 1'b0;
      grf_a3_q <= '0;
      grf_wd_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      grf_we_q <= grf_we_d;
      grf_a3_q <= grf_a3_d;
      grf_wd_q <= grf_wd_d;
    end
  end

  // Entry storage needs no reset: validity comes from the pointers.
  always_ff @(posedge clk) begin
    mem_reg_q  <= mem_reg_d;
    mem_data_q <= mem_data_d;
  end

  assign fifo_count = count_q;
  assign grf_we     = grf_we_q;
  assign grf_a3     = grf_a3_q;
  assign grf_wd     = grf_wd_q;
endmodule

// File: tb/tb_wb_commit_arbiter.sv
// Bench for wb_commit_arbiter: directed cases plus randomized traffic
// checked every cycle against a queue-based model.
module tb_wb_commit_arbiter;
  localparam int DEPTH = 4;
  localparam int LIM   = 8;
  localparam int K_NONE = 0, K_ALU = 1, K_LINK = 2, K_LB = 3;
  localparam int K_LBU = 4, K_LH = 5, K_LHU = 6, K_LW = 7;
  localparam int NT = 35;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [31:0] wb_instr, wb_pc8, wb_alu, wb_dm;
  logic [1:0]  wb_addr_lo;
  logic [4:0]  wb_reg;
  logic        aux_valid;
  logic [4:0]  aux_reg;
  logic [31:0] aux_data;
  logic        aux_ready, wb_stall;
  logic [4:0]  query_reg;
  logic        pend_hit;
  logic [2:0]  fifo_count;
  logic        grf_we;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd;

  always #5 clk = ~clk;

  wb_commit_arbiter dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_instr(wb_instr),
    .wb_pc8(wb_pc8), .wb_alu(wb_alu), .wb_dm(wb_dm),
    .wb_addr_lo(wb_addr_lo), .wb_reg(wb_reg),
    .aux_valid(aux_valid), .aux_reg(aux_reg),
    .aux_data(aux_data), .aux_ready(aux_ready),
    .wb_stall(wb_stall), .query_reg(query_reg),
    .pend_hit(pend_hit), .fifo_count(fifo_count),
    .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd)
  );

  int total = 0;
  int bad   = 0;

  // model state
  int          q_reg[$];
  logic [31:0] q_dat[$];
  int          m_starve;
  logic        m_we;
  logic [4:0]  m_a3;
  logic [31:0] m_wd;
  int          cur_k;

  logic [31:0] tw [NT];
  int          tk [NT];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ld_val(int k, logic [31:0] dm,
                                         logic [1:0] lo);
    logic [31:0] b, h;
    b = (dm >> (8 * lo)) & 32'hFF;
    h = (dm >> (16 * lo[1])) & 32'hFFFF;
    case (k)
      K_LB:    return (b >= 128) ? (b | 32'hFFFFFF00) : b;
      K_LBU:   return b;
      K_LH:    return (h >= 32768) ? (h | 32'hFFFF0000) : h;
      K_LHU:   return h;
      default: return dm;
    endcase
  endfunction

  task automatic drv(logic [31:0] w, int k);
    wb_instr = w;
    cur_k    = k;
  endtask

  task automatic model_reset();
    q_reg.delete();
    q_dat.delete();
    m_starve = 0;
    m_we = 1'b0;
    m_a3 = '0;
    m_wd = '0;
  endtask

  // one clock: compare at negedge, advance model, return at posedge+1
  task automatic step();
    int sz;
    bit ne, stall, p, pop, push, hit;
    logic [31:0] pd;
    @(negedge clk);
    sz    = q_reg.size();
    ne    = (sz > 0);
    stall = ne && (m_starve == LIM);
    hit   = 1'b0;
    if (query_reg != 0)
      foreach (q_reg[i]) if (q_reg[i] == int'(query_reg)) hit = 1'b1;
    chk("aux_ready", 32'(aux_ready), 32'(sz < DEPTH));
    chk("wb_stall", 32'(wb_stall), 32'(stall));
    chk("fifo_count", 32'(fifo_count), 32'(sz));
    chk("pend_hit", 32'(pend_hit), 32'(hit));
    chk("grf_we", 32'(grf_we), 32'(m_we));
    chk("grf_a3", 32'(grf_a3), 32'(m_a3));
    chk("grf_wd", grf_wd, m_wd);
    if (reset) begin
      model_reset();
    end else begin
      p    = wb_valid && cur_k != K_NONE && wb_reg != 0;
      pop  = ne && (!p || stall);
      push = aux_valid && sz < DEPTH && aux_reg != 0;
      case (cur_k)
        K_ALU:   pd = wb_alu;
        K_LINK:  pd = wb_pc8;
        default: pd = ld_val(cur_k, wb_dm, wb_addr_lo);
      endcase
      if (pop) begin
        m_we = 1'b1;
        m_a3 = 5'(q_reg[0]);
        m_wd = q_dat[0];
      end else if (p) begin
        m_we = 1'b1;
        m_a3 = wb_reg;
        m_wd = pd;
      end else begin
        m_we = 1'b0;
      end
      if (!ne || pop) m_starve = 0;
      else if (p && m_starve < LIM) m_starve++;
      if (pop) begin
        void'(q_reg.pop_front());
        void'(q_dat.pop_front());
      end
      if (push) begin
        q_reg.push_back(int'(aux_reg));
        q_dat.push_back(aux_data);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pct, idx;
    logic [31:0] w;
    tw = '{32'h34000000, 32'h38000000, 32'h30000000, 32'h28000000,
           32'h2C000000, 32'h20000000, 32'h24000000, 32'h3C000000,
           32'h00000021, 32'h00000023, 32'h0000002A, 32'h00000004,
           32'h00000003, 32'h00000010, 32'h00000012, 32'h40000000,
           32'h00000040, 32'h00000000, 32'h10000000, 32'h08000000,
           32'h00000008, 32'hAC000000, 32'hA0000000, 32'h00000011,
           32'h00000018, 32'h0000001B, 32'h40800000, 32'hFC000000,
           32'h0C000000, 32'h00000009, 32'h80000000, 32'h90000000,
           32'h84000000, 32'h94000000, 32'h8C000000};
    tk = '{K_ALU, K_ALU, K_ALU, K_ALU, K_ALU, K_ALU, K_ALU, K_ALU,
           K_ALU, K_ALU, K_ALU, K_ALU, K_ALU, K_ALU, K_ALU, K_ALU,
           K_ALU, K_NONE, K_NONE, K_NONE, K_NONE, K_NONE, K_NONE,
           K_NONE, K_NONE, K_NONE, K_NONE, K_NONE, K_LINK, K_LINK,
           K_LB, K_LBU, K_LH, K_LHU, K_LW};
    reset = 1'b1; wb_valid = 0; wb_instr = 0; cur_k = K_NONE;
    wb_pc8 = 0; wb_alu = 0; wb_dm = 0; wb_addr_lo = 0; wb_reg = 0;
    aux_valid = 0; aux_reg = 0; aux_data = 0; query_reg = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    reset = 1'b0;
    chk("rst_we", 32'(grf_we), 0);
    chk("rst_a3", 32'(grf_a3), 0);
    chk("rst_wd", grf_wd, 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_ready", 32'(aux_ready), 1);

    // link / no-write
    wb_valid = 1; wb_reg = 31; wb_pc8 = 32'h3008;
    drv(32'h0C000000, K_LINK);
    step();
    chk("jal_we", 32'(grf_we), 1);
    chk("jal_a3", 32'(grf_a3), 31);
    chk("jal_wd", grf_wd, 32'h3008);
    drv(32'hAC000000, K_NONE);
    step();
    chk("sw_we", 32'(grf_we), 0);
    wb_reg = 0;
    drv(32'h00000021, K_ALU);
    step();
    chk("r0_we", 32'(grf_we), 0);

    // load extension
    wb_reg = 3; wb_dm = 32'h80FF1234;
    wb_addr_lo = 3; drv(32'h80000000, K_LB); step();
    chk("lb", grf_wd, 32'hFFFFFF80);
    drv(32'h90000000, K_LBU); step();
    chk("lbu", grf_wd, 32'h00000080);
    wb_addr_lo = 2; drv(32'h84000000, K_LH); step();
    chk("lh", grf_wd, 32'hFFFF80FF);
    drv(32'h94000000, K_LHU); step();
    chk("lhu", grf_wd, 32'h000080FF);
    wb_addr_lo = 0; drv(32'h8C000000, K_LW); step();
    chk("lw", grf_wd, 32'h80FF1234);

    // aux with idle pipeline
    wb_valid = 0;
    aux_valid = 1; aux_reg = 5; aux_data = 32'hDEAD;
    step();
    aux_valid = 0;
    chk("aux1_ready", 32'(aux_ready), 1);
    chk("aux1_count", 32'(fifo_count), 1);
    step();
    chk("aux1_we", 32'(grf_we), 1);
    chk("aux1_a3", 32'(grf_a3), 5);
    chk("aux1_wd", grf_wd, 32'hDEAD);
    chk("aux1_count0", 32'(fifo_count), 0);

    // full FIFO and forced drain
    wb_valid = 1; wb_reg = 2; wb_alu = 32'h1111;
    drv(32'h00000021, K_ALU);
    for (int i = 0; i < 4; i++) begin
      aux_valid = 1; aux_reg = 5'(10 + i); aux_data = 32'hA0 + i;
      step();
    end
    aux_valid = 0;
    chk("full_count", 32'(fifo_count), 4);
    chk("full_ready", 32'(aux_ready), 0);
    chk("full_stall", 32'(wb_stall), 0);
    repeat (5) step();
    chk("starve_stall", 32'(wb_stall), 1);
    step();
    chk("drain_we", 32'(grf_we), 1);
    chk("drain_a3", 32'(grf_a3), 10);
    chk("drain_wd", grf_wd, 32'hA0);
    chk("drain_count", 32'(fifo_count), 3);
    chk("drain_stall", 32'(wb_stall), 0);
    wb_valid = 0;
    repeat (5) step();

    // pending-write lookup
    wb_valid = 1;
    aux_valid = 1; aux_reg = 7; aux_data = 32'h77; step();
    aux_reg = 9; aux_data = 32'h99; step();
    aux_valid = 0;
    query_reg = 9; #1;
    chk("pend9", 32'(pend_hit), 1);
    query_reg = 8; #1;
    chk("pend8", 32'(pend_hit), 0);
    query_reg = 0; #1;
    chk("pend0", 32'(pend_hit), 0);
    wb_valid = 0;
    repeat (3) step();
    query_reg = 9; #1;
    chk("pend9_drained", 32'(pend_hit), 0);

    // reset with live entries
    wb_valid = 1;
    for (int i = 0; i < 3; i++) begin
      aux_valid = 1; aux_reg = 5'(4 + i); aux_data = 32'h40 + i;
      step();
    end
    aux_valid = 0;
    chk("pre_rst_count", 32'(fifo_count), 3);
    reset = 1; step(); reset = 0;
    chk("mid_rst_count", 32'(fifo_count), 0);
    chk("mid_rst_we", 32'(grf_we), 0);
    chk("mid_rst_stall", 32'(wb_stall), 0);
    chk("mid_rst_ready", 32'(aux_ready), 1);

    // randomized traffic
    pct = 60;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) pct = (c / 200) % 3 == 0 ? 20 : ((c / 200) % 3 == 1 ? 60 : 100);
      reset = ($urandom_range(0, 199) == 0);
      idx = $urandom_range(0, NT - 1);
      w = tw[idx];
      if (w[31:26] != 6'h00 && w[31:26] != 6'h10) w[15:0] = 16'($urandom);
      drv(w, tk[idx]);
      wb_valid   = ($urandom_range(0, 99) < pct);
      wb_reg     = 5'($urandom_range(0, 31));
      wb_pc8     = $urandom;
      wb_alu     = $urandom;
      wb_dm      = $urandom;
      wb_addr_lo = 2'($urandom);
      aux_valid  = ($urandom_range(0, 2) != 0);
      aux_reg    = 5'($urandom_range(0, 7));
      aux_data   = $urandom;
      query_reg  = 5'($urandom_range(0, 7));
      step();
    end
    reset = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
